// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode/writeback/EX signal bundle for the ID/EX stage
//
// Ports (master = decode/pipeline environment, slave = id_ex_stage):
//   decode in  : id_valid, id_pc, id_imm, id_rs1/rs2_addr, id_rs1/rs2_data,
//                id_alu_op, id_src1_pc, id_src2_imm, id_rd_addr,
//                id_rd_wen, id_mem_ren, id_mem_wen
//   bypass in  : exm_rd_addr, exm_rd_wen, exm_res, wb_rd_addr, wb_rd_wen, wb_data
//   control in : flush, ex_stall
//   outputs    : id_stall, ex_valid, alu_op, alu_src1, alu_src2, ex_store_data,
//                ex_pc, ex_rd_addr, ex_rd_wen, ex_mem_ren, ex_mem_wen
interface id_ex_stage_if #(
  parameter int CPU_WIDTH      = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [CPU_WIDTH-1:0]      id_pc;
  logic [CPU_WIDTH-1:0]      id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [CPU_WIDTH-1:0]      id_rs1_data;
  logic [CPU_WIDTH-1:0]      id_rs2_data;
  logic [ALU_OP_WIDTH-1:0]   id_alu_op;
  logic                      id_src1_pc;
  logic                      id_src2_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic                      id_rd_wen;
  logic                      id_mem_ren;
  logic                      id_mem_wen;
  logic [REG_ADDR_WIDTH-1:0] exm_rd_addr;
  logic                      exm_rd_wen;
  logic [CPU_WIDTH-1:0]      exm_res;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
  logic                      wb_rd_wen;
  logic [CPU_WIDTH-1:0]      wb_data;
  logic                      flush;
  logic                      ex_stall;
  logic                      id_stall;
  logic                      ex_valid;
  logic [ALU_OP_WIDTH-1:0]   alu_op;
  logic [CPU_WIDTH-1:0]      alu_src1;
  logic [CPU_WIDTH-1:0]      alu_src2;
  logic [CPU_WIDTH-1:0]      ex_store_data;
  logic [CPU_WIDTH-1:0]      ex_pc;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_rd_wen;
  logic                      ex_mem_ren;
  logic                      ex_mem_wen;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_alu_op, id_src1_pc, id_src2_imm, id_rd_addr, id_rd_wen, id_mem_ren, id_mem_wen,
           exm_rd_addr, exm_rd_wen, exm_res, wb_rd_addr, wb_rd_wen, wb_data, flush, ex_stall,
    input  id_stall, ex_valid, alu_op, alu_src1, alu_src2, ex_store_data, ex_pc,
           ex_rd_addr, ex_rd_wen, ex_mem_ren, ex_mem_wen
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_alu_op, id_src1_pc, id_src2_imm, id_rd_addr, id_rd_wen, id_mem_ren, id_mem_wen,
           exm_rd_addr, exm_rd_wen, exm_res, wb_rd_addr, wb_rd_wen, wb_data, flush, ex_stall,
    output id_stall, ex_valid, alu_op, alu_src1, alu_src2, ex_store_data, ex_pc,
           ex_rd_addr, ex_rd_wen, ex_mem_ren, ex_mem_wen
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
//
// Ports:
//   clk   : stage clock
//   rst_n : asynchronous active-low reset, clears every stage field
//   bus   : id_ex_stage_if.slave - decode inputs, MEM/WB bypass inputs,
//           flush/ex_stall controls, resolved ALU operands and EX control out
module id_ex_stage #(
  parameter int CPU_WIDTH      = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic                      valid_q;
  logic [CPU_WIDTH-1:0]      pc_q;
  logic [CPU_WIDTH-1:0]      imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
  logic [CPU_WIDTH-1:0]      rs1_data_q;
  logic [CPU_WIDTH-1:0]      rs2_data_q;
  logic [ALU_OP_WIDTH-1:0]   alu_op_q;
  logic                      src1_pc_q;
  logic                      src2_imm_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic                      rd_wen_q;
  logic                      mem_ren_q;
  logic                      mem_wen_q;

  logic                      load_use;
  logic [CPU_WIDTH-1:0]      fwd_rs1;
  logic [CPU_WIDTH-1:0]      fwd_rs2;

  // Conservative: a matching rs index stalls even if the operand is replaced by PC/imm.
  assign load_use = bus.id_valid & valid_q & mem_ren_q & rd_wen_q &
                    (rd_addr_q != '0) &
                    ((rd_addr_q == bus.id_rs1_addr) | (rd_addr_q == bus.id_rs2_addr));

  assign bus.id_stall = load_use | bus.ex_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      alu_op_q   <= '0;
      src1_pc_q  <= 1'b0;
      src2_imm_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_wen_q   <= 1'b0;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
    end else if (bus.flush) begin
      // A killed instruction must not leave side effects even while EX is stalled.
      valid_q   <= 1'b0;
      rd_wen_q  <= 1'b0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
    end else if (bus.ex_stall) begin
      // Hold every field.
    end else if (load_use) begin
      valid_q <= 1'b0;
    end else begin
      valid_q    <= bus.id_valid;
      pc_q       <= bus.id_pc;
      imm_q      <= bus.id_imm;
      rs1_addr_q <= bus.id_rs1_addr;
      rs2_addr_q <= bus.id_rs2_addr;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      alu_op_q   <= bus.id_alu_op;
      src1_pc_q  <= bus.id_src1_pc;
      src2_imm_q <= bus.id_src2_imm;
      rd_addr_q  <= bus.id_rd_addr;
      rd_wen_q   <= bus.id_rd_wen;
      mem_ren_q  <= bus.id_mem_ren;
      mem_wen_q  <= bus.id_mem_wen;
    end
  end

  // MEM is younger than WB, so it wins; x0 always reads as zero.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_addr_q == '0) begin
      fwd_rs1 = '0;
    end else if (bus.exm_rd_wen && (bus.exm_rd_addr == rs1_addr_q)) begin
      fwd_rs1 = bus.exm_res;
    end else if (bus.wb_rd_wen && (bus.wb_rd_addr == rs1_addr_q)) begin
      fwd_rs1 = bus.wb_data;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (rs2_addr_q == '0) begin
      fwd_rs2 = '0;
    end else if (bus.exm_rd_wen && (bus.exm_rd_addr == rs2_addr_q)) begin
      fwd_rs2 = bus.exm_res;
    end else if (bus.wb_rd_wen && (bus.wb_rd_addr == rs2_addr_q)) begin
      fwd_rs2 = bus.wb_data;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.alu_src1      = src1_pc_q  ? pc_q  : fwd_rs1;
  assign bus.alu_src2      = src2_imm_q ? imm_q : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_rd_wen     = rd_wen_q  & valid_q;
  assign bus.ex_mem_ren    = mem_ren_q & valid_q;
  assign bus.ex_mem_wen    = mem_wen_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [3:0]  op;
    logic        s1pc;
    logic        s2imm;
    logic [4:0]  rd;
    logic        rdw;
    logic        mr;
    logic        mw;
  } instr_t;

  logic   clk = 1'b0;
  logic   rst_n;
  int     vec_cnt = 0;
  int     err_cnt = 0;
  instr_t m;

  id_ex_stage_if #(.CPU_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.CPU_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic instr_t decode_word();
    instr_t d;
    d.valid = bus.id_valid;    d.pc    = bus.id_pc;       d.imm   = bus.id_imm;
    d.rs1a  = bus.id_rs1_addr; d.rs2a  = bus.id_rs2_addr;
    d.rs1d  = bus.id_rs1_data; d.rs2d  = bus.id_rs2_data;
    d.op    = bus.id_alu_op;   d.s1pc  = bus.id_src1_pc;  d.s2imm = bus.id_src2_imm;
    d.rd    = bus.id_rd_addr;  d.rdw   = bus.id_rd_wen;
    d.mr    = bus.id_mem_ren;  d.mw    = bus.id_mem_wen;
    return d;
  endfunction

  // Value an EX operand should read: youngest in-flight writer of that register.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (bus.exm_rd_wen && bus.exm_rd_addr == a) return bus.exm_res;
    if (bus.wb_rd_wen && bus.wb_rd_addr == a) return bus.wb_data;
    return rf;
  endfunction

  function automatic bit model_load_use();
    return bus.id_valid && m.valid && m.mr && m.rdw && m.rd != 0 &&
           (m.rd == bus.id_rs1_addr || m.rd == bus.id_rs2_addr);
  endfunction

  task automatic model_check();
    logic [31:0] r1, r2;
    r1 = operand(m.rs1a, m.rs1d);
    r2 = operand(m.rs2a, m.rs2d);
    check("id_stall",   {31'd0, bus.id_stall},   {31'd0, model_load_use() | bus.ex_stall});
    check("ex_valid",   {31'd0, bus.ex_valid},   {31'd0, m.valid});
    check("ex_rd_wen",  {31'd0, bus.ex_rd_wen},  {31'd0, m.valid & m.rdw});
    check("ex_mem_ren", {31'd0, bus.ex_mem_ren}, {31'd0, m.valid & m.mr});
    check("ex_mem_wen", {31'd0, bus.ex_mem_wen}, {31'd0, m.valid & m.mw});
    if (m.valid) begin
      check("alu_op",     {28'd0, bus.alu_op},   {28'd0, m.op});
      check("alu_src1",   bus.alu_src1,          m.s1pc  ? m.pc  : r1);
      check("alu_src2",   bus.alu_src2,          m.s2imm ? m.imm : r2);
      check("store_data", bus.ex_store_data,     r2);
      check("ex_pc",      bus.ex_pc,             m.pc);
      check("ex_rd_addr", {27'd0, bus.ex_rd_addr}, {27'd0, m.rd});
    end
  endtask

  // One clock: check mid-cycle, advance the model at the edge, return just after it.
  task automatic step();
    bit lu;
    @(negedge clk);
    model_check();
    lu = model_load_use();
    @(posedge clk);
    if (!rst_n)           m = '0;
    else if (bus.flush) begin
      m.valid = 0; m.rdw = 0; m.mr = 0; m.mw = 0;
    end
    else if (bus.ex_stall) ;
    else if (lu)          m.valid = 0;
    else                  m = decode_word();
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_imm = 0;
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_alu_op = 0; bus.id_src1_pc = 0; bus.id_src2_imm = 0; bus.id_rd_addr = 0;
    bus.id_rd_wen = 0; bus.id_mem_ren = 0; bus.id_mem_wen = 0;
    bus.exm_rd_addr = 0; bus.exm_rd_wen = 0; bus.exm_res = 0;
    bus.wb_rd_addr = 0; bus.wb_rd_wen = 0; bus.wb_data = 0;
    bus.flush = 0; bus.ex_stall = 0;
  endtask

  // Small register range so forwarding and load-use hit often.
  task automatic rand_inputs();
    bus.id_valid    = ($urandom % 4) != 0;
    bus.id_pc       = $urandom;          bus.id_imm      = $urandom;
    bus.id_rs1_addr = 5'($urandom_range(0, 3));
    bus.id_rs2_addr = 5'($urandom_range(0, 3));
    bus.id_rs1_data = $urandom;          bus.id_rs2_data = $urandom;
    bus.id_alu_op   = 4'($urandom);
    bus.id_src1_pc  = 1'($urandom);      bus.id_src2_imm = 1'($urandom);
    bus.id_rd_addr  = 5'($urandom_range(0, 3));
    bus.id_rd_wen   = 1'($urandom);      bus.id_mem_ren  = 1'($urandom);
    bus.id_mem_wen  = 1'($urandom);
    bus.exm_rd_addr = 5'($urandom_range(0, 3));
    bus.exm_rd_wen  = 1'($urandom);      bus.exm_res     = $urandom;
    bus.wb_rd_addr  = 5'($urandom_range(0, 3));
    bus.wb_rd_wen   = 1'($urandom);      bus.wb_data     = $urandom;
    bus.flush       = ($urandom % 10) == 0;
    bus.ex_stall    = ($urandom % 6) == 0;
  endtask

  initial begin
    rst_n = 0;
    m = '0;
    clear_inputs();
    step();
    step();
    rst_n = 1;

    // Forward from MEM, MEM over WB.
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1_addr = 1; bus.id_rs2_addr = 2;
    bus.id_rs1_data = 5; bus.id_rs2_data = 7; bus.id_rd_addr = 3; bus.id_rd_wen = 1;
    step();
    clear_inputs();
    bus.exm_rd_addr = 1; bus.exm_rd_wen = 1; bus.exm_res = 100;
    #1;
    check("fwd_mem_src1", bus.alu_src1, 32'd100);
    check("fwd_mem_src2", bus.alu_src2, 32'd7);
    bus.exm_rd_addr = 2; bus.exm_res = 9; bus.wb_rd_addr = 2; bus.wb_rd_wen = 1; bus.wb_data = 4;
    #1;
    check("mem_over_wb", bus.alu_src2, 32'd9);
    step();

    // x0 is never forwarded.
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1_data = 32'h123;
    step();
    clear_inputs();
    bus.exm_rd_addr = 0; bus.exm_rd_wen = 1; bus.exm_res = 55;
    bus.wb_rd_addr = 0; bus.wb_rd_wen = 1; bus.wb_data = 66;
    #1;
    check("x0_src1", bus.alu_src1, 32'd0);
    step();

    // Load-use: lw x5 in EX, add x6,x5,x1 in decode.
    clear_inputs();
    bus.id_valid = 1; bus.id_rd_addr = 5; bus.id_rd_wen = 1; bus.id_mem_ren = 1; bus.id_rs1_addr = 2;
    step();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1_addr = 5; bus.id_rs2_addr = 1; bus.id_rs1_data = 32'h1111;
    bus.id_rd_addr = 6; bus.id_rd_wen = 1;
    #1;
    check("lu_stall", {31'd0, bus.id_stall}, 32'd1);
    step();
    #1;
    check("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    check("lu_stall_one_cycle", {31'd0, bus.id_stall}, 32'd0);
    step();
    clear_inputs();
    bus.wb_rd_addr = 5; bus.wb_rd_wen = 1; bus.wb_data = 32'hDEAD_BEEF;
    #1;
    check("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("lu_wb_fwd", bus.alu_src1, 32'hDEAD_BEEF);
    step();

    // ex_stall holds for 3 cycles.
    clear_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h40; bus.id_rs1_addr = 7; bus.id_rs1_data = 32'h11;
    bus.id_alu_op = 4'h3; bus.id_rd_addr = 8; bus.id_rd_wen = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      bus.ex_stall = 1; bus.id_valid = 1; bus.id_pc = $urandom; bus.id_rs1_data = $urandom;
      #1;
      check("stall_id_stall", {31'd0, bus.id_stall}, 32'd1);
      check("stall_valid", {31'd0, bus.ex_valid}, 32'd1);
      check("stall_src1", bus.alu_src1, 32'h11);
      check("stall_pc", bus.ex_pc, 32'h40);
      check("stall_op", {28'd0, bus.alu_op}, 32'h3);
      step();
    end

    // Flush overrides ex_stall.
    clear_inputs();
    bus.id_valid = 1; bus.id_mem_wen = 1;
    step();
    clear_inputs();
    bus.flush = 1; bus.ex_stall = 1;
    step();
    clear_inputs();
    #1;
    check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("flush_mem_wen", {31'd0, bus.ex_mem_wen}, 32'd0);

    // Flush together with load-use: stall still reported, EX invalid.
    bus.id_valid = 1; bus.id_rd_addr = 4; bus.id_rd_wen = 1; bus.id_mem_ren = 1;
    step();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs2_addr = 4; bus.flush = 1;
    #1;
    check("flush_lu_stall", {31'd0, bus.id_stall}, 32'd1);
    step();
    clear_inputs();
    #1;
    check("flush_lu_valid", {31'd0, bus.ex_valid}, 32'd0);

    // PC / immediate select; store data still follows rs2.
    bus.id_valid = 1; bus.id_src1_pc = 1; bus.id_src2_imm = 1;
    bus.id_pc = 32'h100; bus.id_imm = 32'hFFFF_FFFC; bus.id_rs2_addr = 3; bus.id_rs2_data = 32'hABCD;
    step();
    clear_inputs();
    #1;
    check("sel_src1_pc", bus.alu_src1, 32'h100);
    check("sel_src2_imm", bus.alu_src2, 32'hFFFF_FFFC);
    check("sel_store", bus.ex_store_data, 32'hABCD);
    step();

    // Randomized run with occasional mid-cycle reset.
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      if (n % 150 == 149) begin
        bus.ex_stall = 0;
        #2;
        rst_n = 0;
        m = '0;
        #1;
        check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_src1", bus.alu_src1, 32'd0);
        check("rst_src2", bus.alu_src2, 32'd0);
        check("rst_rd_wen", {31'd0, bus.ex_rd_wen}, 32'd0);
        check("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
        check("rst_id_stall", {31'd0, bus.id_stall}, 32'd0);
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
